// File: rtl/voice_alloc.sv
// Four-voice note allocator: maps MIDI note-on/off events onto a voice bank
// with retrigger, free-voice search and optional oldest-voice stealing.
module voice_alloc #(
  parameter bit STEAL_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       EV_VALID,
  output logic       EV_READY,
  input  logic       EV_ON,
  input  logic [6:0] EV_NUM,
  input  logic [6:0] EV_VEL,
  input  logic       ALL_OFF,
  output logic [6:0] NOTE_NUM_0,
  output logic [6:0] NOTE_NUM_1,
  output logic [6:0] NOTE_NUM_2,
  output logic [6:0] NOTE_NUM_3,
  output logic [6:0] NOTE_VEL_0,
  output logic [6:0] NOTE_VEL_1,
  output logic [6:0] NOTE_VEL_2,
  output logic [6:0] NOTE_VEL_3,
  output logic [3:0] ACTIVE,
  output logic       DROP
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic       ev_on_r;
  logic [6:0] ev_num_r, ev_vel_r;
  logic [3:0] match_r, free_r, match_s, free_s;
  logic [6:0] num_r [4];
  logic [6:0] vel_r [4];
  logic [1:0] rank_r [4];
  logic [6:0] num_s [4];
  logic [6:0] vel_s [4];
  logic [1:0] rank_s [4];
  logic [3:0] active_r, active_s;
  logic       drop_r, drop_s;
  logic       accept_s, is_on_s, tgt_ok_s;
  logic [1:0] tgt_s, oldest_s;

  function automatic logic [1:0] lowest_idx(input logic [3:0] vec);
    casez (vec)
      4'b???1: lowest_idx = 2'd0;
      4'b??10: lowest_idx = 2'd1;
      4'b?100: lowest_idx = 2'd2;
      default: lowest_idx = 2'd3;
    endcase
  endfunction

  assign EV_READY   = CE & (state_r == ST_IDLE);
  assign accept_s   = EV_READY & EV_VALID & ~ALL_OFF;
  assign NOTE_NUM_0 = num_r[0];
  assign NOTE_NUM_1 = num_r[1];
  assign NOTE_NUM_2 = num_r[2];
  assign NOTE_NUM_3 = num_r[3];
  assign NOTE_VEL_0 = vel_r[0];
  assign NOTE_VEL_1 = vel_r[1];
  assign NOTE_VEL_2 = vel_r[2];
  assign NOTE_VEL_3 = vel_r[3];
  assign ACTIVE     = active_r;
  assign DROP       = drop_r;

  // Next-state logic; ALL_OFF aborts any event in flight.
  always_comb begin
    state_s = state_r;
    if (ALL_OFF) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_s = EV_VALID ? ST_SCAN : ST_IDLE;
        ST_SCAN:   state_s = ST_COMMIT;
        ST_COMMIT: state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Voice match/free vectors captured during SCAN.
  always_comb begin
    match_s = 4'b0000;
    free_s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      match_s[i] = (vel_r[i] != 7'd0) && (num_r[i] == ev_num_r);
      free_s[i]  = (vel_r[i] == 7'd0);
    end
  end

  // Target voice selection: retrigger, then free, then steal rank-3 voice.
  always_comb begin
    is_on_s  = ev_on_r & (ev_vel_r != 7'd0);
    oldest_s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rank_r[i] == 2'd3) oldest_s = 2'(i);
      else                   oldest_s = oldest_s;
    end
    if (|match_r) begin
      tgt_s    = lowest_idx(match_r);
      tgt_ok_s = 1'b1;
    end else if (|free_r) begin
      tgt_s    = lowest_idx(free_r);
      tgt_ok_s = 1'b1;
    end else if (STEAL_EN) begin
      tgt_s    = oldest_s;
      tgt_ok_s = 1'b1;
    end else begin
      tgt_s    = 2'd0;
      tgt_ok_s = 1'b0;
    end
  end

  // Voice bank, age rank and drop-pulse update.
  always_comb begin
    num_s  = num_r;
    vel_s  = vel_r;
    rank_s = rank_r;
    drop_s = 1'b0;
    if (ALL_OFF) begin
      for (int i = 0; i < 4; i++) vel_s[i] = 7'd0;
    end else if (state_r == ST_COMMIT) begin
      if (is_on_s) begin
        if (tgt_ok_s) begin
          num_s[tgt_s] = ev_num_r;
          vel_s[tgt_s] = ev_vel_r;
          // Target becomes newest; voices younger than it age by one.
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == tgt_s)                rank_s[i] = 2'd0;
            else if (rank_r[i] < rank_r[tgt_s]) rank_s[i] = rank_r[i] + 2'd1;
            else                                rank_s[i] = rank_r[i];
          end
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (match_r[i]) vel_s[i] = 7'd0;
          else            vel_s[i] = vel_r[i];
        end
      end
    end else begin
      drop_s = 1'b0;
    end
    active_s = 4'b0000;
    for (int i = 0; i < 4; i++) active_s[i] = (vel_s[i] != 7'd0);
  end

  // State registers; CE low freezes everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      ev_on_r  <= 1'b0;
      ev_num_r <= 7'd0;
      ev_vel_r <= 7'd0;
      match_r  <= 4'b0000;
      free_r   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        num_r[i]  <= 7'd0;
        vel_r[i]  <= 7'd0;
        rank_r[i] <= 2'(i);
      end
      active_r <= 4'b0000;
      drop_r   <= 1'b0;
    end else if (CE) begin
      state_r <= state_s;
      if (accept_s) begin
        ev_on_r  <= EV_ON;
        ev_num_r <= EV_NUM;
        ev_vel_r <= EV_VEL;
      end
      if (state_r == ST_SCAN) begin
        match_r <= match_s;
        free_r  <= free_s;
      end
      num_r    <= num_s;
      vel_r    <= vel_s;
      rank_r   <= rank_s;
      active_r <= active_s;
      drop_r   <= drop_s;
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: steal and no-steal instances share stimulus and are
// checked against a timestamp-based voice model.
module tb_voice_alloc;

  logic       CLK = 1'b0;
  logic       RST, CE, EV_VALID, EV_ON, ALL_OFF;
  logic [6:0] EV_NUM, EV_VEL;
  logic       ready [2];
  logic [6:0] nn [2][4];
  logic [6:0] nv [2][4];
  logic [3:0] act [2];
  logic       drop [2];

  int n_checks = 0;
  int n_fail   = 0;

  // model: index 0 = STEAL_EN=1, index 1 = STEAL_EN=0
  int mnum [2][4];
  int mvel [2][4];
  int mstamp [2][4];
  int mdrop [2];
  int mtime = 0;

  always #5 CLK = ~CLK;

  voice_alloc #(.STEAL_EN(1'b1)) dut_s (
    .CLK(CLK), .RST(RST), .CE(CE), .EV_VALID(EV_VALID), .EV_READY(ready[0]),
    .EV_ON(EV_ON), .EV_NUM(EV_NUM), .EV_VEL(EV_VEL), .ALL_OFF(ALL_OFF),
    .NOTE_NUM_0(nn[0][0]), .NOTE_NUM_1(nn[0][1]), .NOTE_NUM_2(nn[0][2]), .NOTE_NUM_3(nn[0][3]),
    .NOTE_VEL_0(nv[0][0]), .NOTE_VEL_1(nv[0][1]), .NOTE_VEL_2(nv[0][2]), .NOTE_VEL_3(nv[0][3]),
    .ACTIVE(act[0]), .DROP(drop[0]));

  voice_alloc #(.STEAL_EN(1'b0)) dut_n (
    .CLK(CLK), .RST(RST), .CE(CE), .EV_VALID(EV_VALID), .EV_READY(ready[1]),
    .EV_ON(EV_ON), .EV_NUM(EV_NUM), .EV_VEL(EV_VEL), .ALL_OFF(ALL_OFF),
    .NOTE_NUM_0(nn[1][0]), .NOTE_NUM_1(nn[1][1]), .NOTE_NUM_2(nn[1][2]), .NOTE_NUM_3(nn[1][3]),
    .NOTE_VEL_0(nv[1][0]), .NOTE_VEL_1(nv[1][1]), .NOTE_VEL_2(nv[1][2]), .NOTE_VEL_3(nv[1][3]),
    .ACTIVE(act[1]), .DROP(drop[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        mnum[m][i] = 0; mvel[m][i] = 0; mstamp[m][i] = -i;
      end
      mdrop[m] = 0;
    end
  endfunction

  function automatic void model_alloff();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) mvel[m][i] = 0;
      mdrop[m] = 0;
    end
  endfunction

  // Note-on claims a voice and stamps it with the current time; oldest = min stamp.
  function automatic void model_event(input int on, input int num, input int vel);
    mtime++;
    for (int m = 0; m < 2; m++) begin
      int tgt;
      mdrop[m] = 0;
      tgt = -1;
      if (on != 0 && vel != 0) begin
        for (int i = 3; i >= 0; i--) if (mvel[m][i] != 0 && mnum[m][i] == num) tgt = i;
        if (tgt < 0) for (int i = 3; i >= 0; i--) if (mvel[m][i] == 0) tgt = i;
        if (tgt < 0 && m == 0) begin
          tgt = 0;
          for (int i = 1; i < 4; i++) if (mstamp[m][i] < mstamp[m][tgt]) tgt = i;
        end
        if (tgt < 0) mdrop[m] = 1;
        else begin
          mnum[m][tgt] = num; mvel[m][tgt] = vel; mstamp[m][tgt] = mtime;
        end
      end else begin
        for (int i = 0; i < 4; i++) if (mvel[m][i] != 0 && mnum[m][i] == num) mvel[m][i] = 0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic [3:0] ea;
      ea = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s.m%0d.num%0d", tag, m, i), nn[m][i], mnum[m][i]);
        chk($sformatf("%s.m%0d.vel%0d", tag, m, i), nv[m][i], mvel[m][i]);
        ea[i] = (mvel[m][i] != 0);
      end
      chk($sformatf("%s.m%0d.active", tag, m), act[m], ea);
      chk($sformatf("%s.m%0d.drop", tag, m), drop[m], mdrop[m]);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".in"});
    @(negedge CLK);
    RST = 1'b0;
    #1;
    compare_all({tag, ".out"});
  endtask

  // Present one event, scramble inputs while busy, check after the commit edge.
  task automatic do_event(input int on, input int num, input int vel, input string tag);
    @(negedge CLK);
    chk({tag, ".drop_clear0"}, drop[0], 1'b0);
    chk({tag, ".drop_clear1"}, drop[1], 1'b0);
    chk({tag, ".ready"}, ready[0], 1'b1);
    EV_VALID = 1'b1; EV_ON = on[0]; EV_NUM = num[6:0]; EV_VEL = vel[6:0];
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, ".busy"}, ready[0], 1'b0);
    EV_VALID = 1'($urandom); EV_ON = 1'($urandom);
    EV_NUM = 7'($urandom); EV_VEL = 7'($urandom);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    EV_VALID = 1'b0;
    model_event(on, num, vel);
    compare_all(tag);
    chk({tag, ".ready_again"}, ready[1], 1'b1);
  endtask

  initial begin
    RST = 1'b1; CE = 1'b1; EV_VALID = 1'b0; EV_ON = 1'b0;
    EV_NUM = 7'd0; EV_VEL = 7'd0; ALL_OFF = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    compare_all("rst");
    do_reset("rst2");

    do_event(1, 60, 100, "first_on");
    do_event(1, 62, 90, "on62");
    do_event(1, 64, 80, "on64");
    do_event(1, 65, 70, "on65");
    do_event(1, 67, 60, "steal_or_drop");
    do_event(1, 69, 50, "steal2");

    do_reset("r3");
    do_event(1, 60, 100, "retrig_a");
    do_event(1, 60, 50, "retrig_b");
    do_event(0, 60, 33, "off60");
    do_event(1, 61, 0, "vel0_off_nomatch");

    // ALL_OFF during SCAN of note 70
    do_event(1, 62, 40, "pre_alloff");
    @(negedge CLK);
    EV_VALID = 1'b1; EV_ON = 1'b1; EV_NUM = 7'd70; EV_VEL = 7'd90;
    @(posedge CLK);
    @(negedge CLK);
    EV_VALID = 1'b0; ALL_OFF = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ALL_OFF = 1'b0;
    model_alloff();
    compare_all("alloff");
    chk("alloff.ready", ready[0], 1'b1);
    repeat (2) @(negedge CLK);
    compare_all("alloff.no70");

    // CE low for 5 cycles mid-SCAN
    @(negedge CLK);
    EV_VALID = 1'b1; EV_ON = 1'b1; EV_NUM = 7'd72; EV_VEL = 7'd77;
    @(posedge CLK);
    @(negedge CLK);
    EV_VALID = 1'b0; CE = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    compare_all("ce_hold");
    chk("ce_hold.ready", ready[0], 1'b0);
    CE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    compare_all("ce_scan");
    @(posedge CLK);
    @(negedge CLK);
    model_event(1, 72, 77);
    compare_all("ce_done");

    // reset during COMMIT
    @(negedge CLK);
    EV_VALID = 1'b1; EV_ON = 1'b1; EV_NUM = 7'd74; EV_VEL = 7'd55;
    @(posedge CLK);
    @(negedge CLK);
    EV_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    compare_all("rst_commit");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    compare_all("rst_commit.rel");
    do_event(1, 75, 20, "post_rst");

    // randomized traffic over a narrow note range to force matches and steals
    for (int k = 0; k < 80; k++) begin
      int on, num, vel;
      on  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      num = 60 + $urandom_range(0, 5);
      vel = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
      if ($urandom_range(0, 15) == 0) begin
        @(negedge CLK);
        ALL_OFF = 1'b1;
        @(negedge CLK);
        ALL_OFF = 1'b0;
        model_alloff();
        compare_all($sformatf("rnd_alloff%0d", k));
      end
      do_event(on, num, vel, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter STEAL_EN, default 1, enables stealing of the oldest voice when all 4 voices are busy.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port CE, input, 1 bit: clock enable; when low, all state holds and EV_READY=0.
REQ-005 SHALL have port EV_VALID, input, 1 bit: a MIDI note event is presented.
REQ-006 SHALL have port EV_READY, output, 1 bit: the allocator accepts an event this cycle.
REQ-007 SHALL have port EV_ON, input, 1 bit: 1 = note-on, 0 = note-off.
REQ-008 SHALL have port EV_NUM, input, 7 bits: note number.
REQ-009 SHALL have port EV_VEL, input, 7 bits: note velocity.
REQ-010 SHALL have port ALL_OFF, input, 1 bit: synchronous silence-all request.
REQ-011 SHALL have ports NOTE_NUM_0..NOTE_NUM_3, output, 7 bits each: per-voice note number to the NCO bank.
REQ-012 SHALL have ports NOTE_VEL_0..NOTE_VEL_3, output, 7 bits each: per-voice velocity; 0 = voice free/silent.
REQ-013 SHALL have port ACTIVE, output, 4 bits: bit i = (NOTE_VEL_i != 0).
REQ-014 SHALL have port DROP, output, 1 bit: one-cycle pulse when a note-on is discarded.

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE; each state lasts one enabled cycle.
REQ-016 SHALL drive EV_READY = CE & (state==IDLE).
REQ-017 SHALL accept an event on a rising edge with EV_VALID & EV_READY, latching EV_ON/EV_NUM/EV_VEL and entering SCAN; EV_* are ignored at all other times.
REQ-018 SHALL treat note-on with EV_VEL=0 as note-off.
REQ-019 SHALL in SCAN register match[3:0] (NOTE_VEL_i!=0 and NOTE_NUM_i==latched num) and free[3:0] (NOTE_VEL_i==0).
REQ-020 SHALL on the COMMIT edge for note-on select the target voice by priority: lowest-index match (retrigger); else lowest-index free; else, if STEAL_EN=1, the voice with age rank 3; then write NOTE_NUM and NOTE_VEL of the target.
REQ-021 SHALL, for a note-on with no target (all busy, no match, STEAL_EN=0), leave the voices unchanged and pulse DROP high for the cycle after the COMMIT edge.
REQ-022 SHALL on the COMMIT edge for note-off set NOTE_VEL of every matching voice to 0 and retain NOTE_NUM; no match means no change and no DROP.
REQ-023 SHALL keep a 2-bit age rank per voice forming a permutation of 0..3 (0 = newest).
REQ-024 SHALL, on note-on assignment to voice v, set rank_v to 0 and increment every rank below the old rank_v; note-off SHALL NOT change ranks.
REQ-025 SHALL update outputs on the 2nd edge after the acceptance edge, with EV_READY reasserting in the following cycle (one event per 3 cycles max).
REQ-026 SHALL, when ALL_OFF=1 on an enabled edge, clear all NOTE_VEL to 0, discard any pending event, return the FSM to IDLE, keep ranks, and take priority over COMMIT.
REQ-027 SHALL hold all state when CE=0, including mid-SCAN/COMMIT, and resume on the next enabled cycle.

Reset
REQ-028 SHALL, while RST=1, asynchronously force FSM=IDLE, all NOTE_NUM_i=0, all NOTE_VEL_i=0, ACTIVE=0, DROP=0, rank_i=i, and discard any latched event, including when reset arrives mid-operation.

Verification
REQ-029 SHALL verify: after reset, note-on 60/100 -> accepted with EV_READY=1; 2 edges later NOTE_NUM_0=60, NOTE_VEL_0=100, ACTIVE=0001; EV_READY=1 in the following cycle.
REQ-030 SHALL verify: note-on 60, 62, 64, 65, then 67 (STEAL_EN=1) -> voices 0-3 = 60/62/64/65; 67 replaces voice 0 (oldest), DROP stays 0.
REQ-031 SHALL verify: the same sequence with STEAL_EN=0 -> 67 discarded, DROP high exactly 1 cycle, voices unchanged.
REQ-032 SHALL verify: note-on 60/100, then note-on 60/50 -> voice 0 retriggered to vel 50, voice 1 stays free; then note-off 60 -> NOTE_VEL_0=0, NOTE_NUM_0=60.
REQ-033 SHALL verify: ALL_OFF asserted during SCAN of a note-on 70 -> all velocities 0, event 70 never written, EV_READY=1 the next cycle.
REQ-034 SHALL verify: RST pulsed during COMMIT, or CE held low for 5 cycles mid-SCAN -> reset gives all outputs 0; the CE case completes normally with 5 cycles of added latency.
